// File: rtl/block_packer.sv
// -----------------------------------------------------------------------------
// block_packer
//   Byte/block adapter between the I2C slave byte interface and the DES
//   datapath.  The RX side packs received bytes into one block (first byte
//   in the most significant byte) and holds it until the controller
//   acknowledges it.  The TX side unpacks a result block into bytes, most
//   significant byte first, and pulses next_data once the block is used up.
//
// Parameters
//   NUM_BYTES    bytes per block; block width is 8*NUM_BYTES (64 by default)
//
// Ports
//   clk          system clock
//   n_rst        asynchronous, active-low reset
//   rx_byte      byte from the I2C slave
//   rx_valid     rx_byte valid, one-cycle pulse per byte
//   i2c_stop     one-cycle pulse, STOP condition seen
//   block_ack    controller has consumed data_block
//   data_ready   data_block holds a complete block
//   data_block   packed block, first received byte in the top byte
//   overrun      one-cycle pulse, byte dropped because the RX block is full
//   tx_load      capture tx_block into the TX shift register
//   tx_block     result block from the DES/SRAM read path
//   tx_byte_req  I2C slave requests the next byte, one-cycle pulse
//   tx_byte      current byte to transmit
//   next_data    one-cycle pulse, last TX byte has been taken
//
// Build option
//   PAD_FLUSH_EN  when defined, a STOP on a partial RX block zero-fills it and
//                 presents it as complete; when undefined the partial block
//                 is discarded.
// -----------------------------------------------------------------------------
module block_packer #(
    parameter int NUM_BYTES = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    input  logic                   i2c_stop,
    input  logic                   block_ack,
    output logic                   data_ready,
    output logic [8*NUM_BYTES-1:0] data_block,
    output logic                   overrun,
    input  logic                   tx_load,
    input  logic [8*NUM_BYTES-1:0] tx_block,
    input  logic                   tx_byte_req,
    output logic [7:0]             tx_byte,
    output logic                   next_data
);

    localparam int W  = 8 * NUM_BYTES;
    localparam int CW = $clog2(NUM_BYTES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [W-1:0]  block_nxt;
    logic          ready_nxt;
    logic          overrun_nxt;

    logic [W-1:0]  tx_shift;
    logic [CW-1:0] tx_cnt;

    // RX next-state logic.  The first byte of every block clears the whole
    // block register, so the unused tail is already zero when a STOP arrives
    // early; padding then needs no extra write.  The byte of the current
    // cycle is accounted for first, and only then is the resulting byte
    // count classified (complete / partial) and the STOP applied.  A block
    // sitting in FULL always carries cnt == NUM_BYTES so that it is never
    // mistaken for a partial block.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        block_nxt   = data_block;
        ready_nxt   = data_ready;
        overrun_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    block_nxt          = '0;
                    block_nxt[W-1 -: 8] = rx_byte;
                    cnt_nxt            = CW'(1);
                end
            end
            ST_FILL: begin
                if (rx_valid) begin
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (cnt == CW'(i)) begin
                            block_nxt[(NUM_BYTES-1-i)*8 +: 8] = rx_byte;
                        end
                    end
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_FULL: begin
                if (block_ack) begin
                    ready_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    if (rx_valid) begin
                        block_nxt          = '0;
                        block_nxt[W-1 -: 8] = rx_byte;
                        cnt_nxt            = CW'(1);
                    end
                end else if (rx_valid) begin
                    overrun_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                ready_nxt = 1'b0;
            end
        endcase

        if (cnt_nxt == CW'(NUM_BYTES)) begin
            state_nxt = ST_FULL;
            ready_nxt = 1'b1;
        end else if (cnt_nxt != '0) begin
            if (i2c_stop) begin
`ifdef PAD_FLUSH_EN
                state_nxt = ST_FULL;
                cnt_nxt   = CW'(NUM_BYTES);
                ready_nxt = 1'b1;
`else
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
`endif
            end else begin
                state_nxt = ST_FILL;
            end
        end
    end

    // RX registers, including the registered data_ready / overrun outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            data_block <= '0;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            data_block <= block_nxt;
            data_ready <= ready_nxt;
            overrun    <= overrun_nxt;
        end
    end

    // TX unpacker.  tx_byte is registered and always mirrors the top byte of
    // the shift register while bytes remain; the byte that becomes current
    // after a request is therefore taken from the second byte of the
    // pre-shift register.  Once the block is exhausted tx_byte idles at FF,
    // and a load always beats a same-cycle request.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_shift  <= '0;
            tx_cnt    <= '0;
            tx_byte   <= 8'h00;
            next_data <= 1'b0;
        end else if (tx_load) begin
            tx_shift  <= tx_block;
            tx_cnt    <= CW'(NUM_BYTES);
            tx_byte   <= tx_block[W-1 -: 8];
            next_data <= 1'b0;
        end else if (tx_byte_req && (tx_cnt != '0)) begin
            tx_shift <= tx_shift << 8;
            tx_cnt   <= tx_cnt - CW'(1);
            if (tx_cnt == CW'(1)) begin
                tx_byte   <= 8'hFF;
                next_data <= 1'b1;
            end else begin
                tx_byte   <= tx_shift[W-9 -: 8];
                next_data <= 1'b0;
            end
        end else begin
            if (tx_byte_req) begin
                tx_byte <= 8'hFF;
            end
            next_data <= 1'b0;
        end
    end

endmodule

// File: tb/tb_block_packer.sv
// -----------------------------------------------------------------------------
// tb_block_packer
//   Self-checking bench for block_packer.  A behavioural model keeps the RX
//   block as a queue of received bytes plus a "full" flag and the TX block as
//   a queue of bytes still to send; every cycle all outputs are compared with
//   it.  Directed steps cover the documented scenarios, followed by a
//   randomized phase.  Honours PAD_FLUSH_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_block_packer;

    localparam int NB = 8;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        i2c_stop = 1'b0;
    logic        block_ack = 1'b0;
    logic        data_ready;
    logic [63:0] data_block;
    logic        overrun;
    logic        tx_load = 1'b0;
    logic [63:0] tx_block = 64'h0;
    logic        tx_byte_req = 1'b0;
    logic [7:0]  tx_byte;
    logic        next_data;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  m_rx_q[$];
    bit          m_full;
    bit          m_overrun;
    logic [7:0]  m_tx_q[$];
    logic [7:0]  m_tx_byte;
    bit          m_next;

    block_packer #(.NUM_BYTES(NB)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .i2c_stop    (i2c_stop),
        .block_ack   (block_ack),
        .data_ready  (data_ready),
        .data_block  (data_block),
        .overrun     (overrun),
        .tx_load     (tx_load),
        .tx_block    (tx_block),
        .tx_byte_req (tx_byte_req),
        .tx_byte     (tx_byte),
        .next_data   (next_data)
    );

    always #5 clk = ~clk;

    // Block as the model sees it: received bytes in order, zeros after them.
    function automatic logic [63:0] packBytes();
        logic [63:0] v = 64'h0;
        for (int i = 0; i < NB; i++) begin
            v = {v[55:0], (i < m_rx_q.size()) ? m_rx_q[i] : 8'h00};
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".data_ready"}, 64'(data_ready), 64'(m_full));
        checkOutput({tag, ".overrun"}, 64'(overrun), 64'(m_overrun));
        checkOutput({tag, ".tx_byte"}, 64'(tx_byte), 64'(m_tx_byte));
        checkOutput({tag, ".next_data"}, 64'(next_data), 64'(m_next));
        if (m_full) begin
            checkOutput({tag, ".data_block"}, data_block, packBytes());
        end
    endtask

    // Advance the model by one cycle for the given inputs.
    task automatic modelStep(input logic rxv, input logic [7:0] rxb, input logic stop,
                             input logic ack, input logic load, input logic [63:0] blk,
                             input logic req);
        m_overrun = 1'b0;
        if (m_full) begin
            if (ack) begin
                m_full = 1'b0;
                m_rx_q.delete();
                if (rxv) m_rx_q.push_back(rxb);
            end else if (rxv) begin
                m_overrun = 1'b1;
            end
        end else if (rxv) begin
            m_rx_q.push_back(rxb);
        end
        if (!m_full) begin
            if (m_rx_q.size() == NB) begin
                m_full = 1'b1;
            end else if (stop && m_rx_q.size() > 0) begin
`ifdef PAD_FLUSH_EN
                m_full = 1'b1;
`else
                m_rx_q.delete();
`endif
            end
        end

        m_next = 1'b0;
        if (load) begin
            m_tx_q.delete();
            for (int i = 0; i < NB; i++) m_tx_q.push_back(blk[63-8*i -: 8]);
            m_tx_byte = m_tx_q[0];
        end else if (req) begin
            if (m_tx_q.size() > 0) begin
                void'(m_tx_q.pop_front());
                if (m_tx_q.size() == 0) begin
                    m_tx_byte = 8'hFF;
                    m_next    = 1'b1;
                end else begin
                    m_tx_byte = m_tx_q[0];
                end
            end else begin
                m_tx_byte = 8'hFF;
            end
        end
    endtask

    // Drive one cycle of inputs, step the model, clock, then compare.
    task automatic applyStimulus(input string tag, input logic rxv, input logic [7:0] rxb,
                                 input logic stop, input logic ack, input logic load,
                                 input logic [63:0] blk, input logic req);
        rx_valid    = rxv;
        rx_byte     = rxb;
        i2c_stop    = stop;
        block_ack   = ack;
        tx_load     = load;
        tx_block    = blk;
        tx_byte_req = req;
        modelStep(rxv, rxb, stop, ack, load, blk, req);
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic rxCycle(input string tag, input logic [7:0] b);
        applyStimulus(tag, 1'b1, b, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic reqCycle(input string tag);
        applyStimulus(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    endtask

    // Assert reset mid-cycle and check outputs clear before any clock edge.
    task automatic doReset(input string tag);
        rx_valid    = 1'b0;
        rx_byte     = 8'h00;
        i2c_stop    = 1'b0;
        block_ack   = 1'b0;
        tx_load     = 1'b0;
        tx_block    = 64'h0;
        tx_byte_req = 1'b0;
        n_rst       = 1'b0;
        m_rx_q.delete();
        m_tx_q.delete();
        m_full    = 1'b0;
        m_overrun = 1'b0;
        m_tx_byte = 8'h00;
        m_next    = 1'b0;
        #2;
        checkOutput({tag, ".data_block"}, data_block, 64'h0);
        checkAll(tag);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    logic [63:0] saved_block;
    logic [7:0]  tx_seq [8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    logic [63:0] rnd_block;

    initial begin
        #1;
        doReset("reset");

        // Basic packing, ready timing and ack
        for (int b = 1; b <= NB; b++) begin
            rxCycle("pack", 8'(b));
            if (b == NB - 1) checkOutput("ready_before_last", 64'(data_ready), 64'h0);
        end
        checkOutput("pack_value", data_block, 64'h0102030405060708);
        checkOutput("pack_ready", 64'(data_ready), 64'h1);
        repeat (3) idleCycle("hold");
        applyStimulus("ack", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        checkOutput("ack_ready_low", 64'(data_ready), 64'h0);

        // Overrun, then ack and byte together
        for (int b = 0; b < NB; b++) rxCycle("fill2", 8'($urandom));
        saved_block = data_block;
        rxCycle("overrun", 8'hAA);
        checkOutput("overrun_pulse", 64'(overrun), 64'h1);
        checkOutput("overrun_frozen", data_block, saved_block);
        idleCycle("overrun_end");
        applyStimulus("ack_and_byte", 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        for (int b = 1; b < NB; b++) rxCycle("fill3", 8'($urandom));
        checkOutput("new_block_first", 64'(data_block[63:56]), 64'h55);
        applyStimulus("ack3", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0);

        // Partial block ended by STOP
        rxCycle("part", 8'h11);
        rxCycle("part", 8'h22);
        rxCycle("part", 8'h33);
        applyStimulus("stop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
`ifdef PAD_FLUSH_EN
        checkOutput("pad_ready", 64'(data_ready), 64'h1);
        checkOutput("pad_block", data_block, 64'h1122330000000000);
        applyStimulus("pad_ack", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
`else
        checkOutput("drop_ready", 64'(data_ready), 64'h0);
        for (int b = 0; b < NB; b++) rxCycle("clean", 8'(8'hA0 + b));
        checkOutput("clean_block", data_block, 64'hA0A1A2A3A4A5A6A7);
        applyStimulus("clean_ack", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
`endif

        // TX unpacking
        applyStimulus("tx_load", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 64'hDEADBEEFCAFEF00D, 1'b0);
        checkOutput("tx_first", 64'(tx_byte), 64'(tx_seq[0]));
        for (int i = 1; i < NB; i++) begin
            reqCycle("tx_req");
            checkOutput("tx_seq", 64'(tx_byte), 64'(tx_seq[i]));
            checkOutput("tx_no_next", 64'(next_data), 64'h0);
            if (i[0]) idleCycle("tx_gap");
        end
        reqCycle("tx_last");
        checkOutput("tx_last_ff", 64'(tx_byte), 64'hFF);
        checkOutput("tx_next_pulse", 64'(next_data), 64'h1);
        idleCycle("tx_next_end");
        checkOutput("tx_next_once", 64'(next_data), 64'h0);
        reqCycle("tx_underrun");
        checkOutput("underrun_ff", 64'(tx_byte), 64'hFF);
        checkOutput("underrun_no_next", 64'(next_data), 64'h0);
        rnd_block = {$urandom, $urandom};
        applyStimulus("load_and_req", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, rnd_block, 1'b1);
        checkOutput("load_wins", 64'(tx_byte), 64'(rnd_block[63:56]));
        reqCycle("after_load_req");

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            applyStimulus("random",
                          1'($urandom_range(0, 99) < 55), 8'($urandom),
                          1'($urandom_range(0, 99) < 5), 1'($urandom_range(0, 99) < 20),
                          1'($urandom_range(0, 99) < 6), {$urandom, $urandom},
                          1'($urandom_range(0, 99) < 40));
        end

        // Mid-block reset discards both sides
        doReset("reset2");
        applyStimulus("mid_load", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 64'h0123456789ABCDEF, 1'b0);
        for (int b = 0; b < 5; b++) begin
            applyStimulus("mid_rx", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 64'h0, 1'(b < 3));
        end
        doReset("reset_mid");
        for (int b = 0; b < NB; b++) rxCycle("post_reset", 8'(8'h40 + b));
        checkOutput("post_reset_block", data_block, 64'h4041424344454647);
        checkOutput("post_reset_ready", 64'(data_ready), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
